cg_iteration_sequencer: RTL and testbench
=========================================

Name: cg_iteration_sequencer

Overview:
- Central FSM for the conjugate-gradient datapath.
- Issues one-cycle start pulses to these units, in dependency order:
  - r·r dot product
  - A·p matrix-vector multiply
  - p·Ap dot product
  - alpha divider
  - x/r update units
  - rsnew dot product
  - beta divider
  - p update unit
- Collects each unit's done, holds rsold/rsnew, checks convergence and counts iterations.
- Replaces the scattered start/flag registers inside the ALU top level; the top level only wires pulses and results.

Parameters:
- TOLERANCE, 32'h283424DC, convergence threshold. Raw IEEE-754 single bit pattern, compared unsigned against rsnew, which is always non-negative.
- MAX_ITER, 64, iteration limit before giving up.
- ITER_W, 16, width of iter_count.
- WDOG_LIMIT, 4096, per-stage cycle limit. Used only with CG_WATCHDOG_EN.

Ports:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- go  in  1  start a solve; sampled only in IDLE
- rr_start  out  1  pulse: r·r dot product
- rr_done  in  1  r·r result valid
- rr_result  in  32  rsold from r·r
- ap_start  out  1  pulse: A·p multiply
- ap_done  in  1  A·p finished
- pap_start  out  1  pulse: p·Ap dot product
- pap_done  in  1  p·Ap finished
- alpha_start  out  1  pulse: alpha = rsold/pAp
- alpha_done  in  1  alpha valid
- xr_start  out  1  pulse: x and r updates together
- x_done  in  1  x update finished
- r_done  in  1  r update finished
- rsnew_start  out  1  pulse: rsnew dot product
- rsnew_done  in  1  rsnew valid
- rsnew_result  in  32  rsnew value
- beta_start  out  1  pulse: beta = rsnew/rsold
- beta_done  in  1  beta valid
- p_start  out  1  pulse: p update
- p_done  in  1  p update finished
- rold  out  32  current rsold, divisor operand for beta
- rnew  out  32  latched rsnew, dividend operand for beta
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of solve
- converged  out  1  solve ended below TOLERANCE
- iter_count  out  ITER_W  completed iterations
- timeout_err  out  1  watchdog fired (CG_WATCHDOG_EN only; otherwise tied 0)

Behaviour:
- Reset: all outputs 0; state IDLE; internal first_iter flag set to 1.
- Reset mid-solve: abandons the solve the same edge; no start pulse appears in the following cycle.
- Start pulses:
  - Registered; high for exactly the first cycle after entering their state.
  - Never re-issued while waiting in that state.
- States and transitions:
  - IDLE: on go=1 → RR_AP. Clears converged, iter_count and first_iter-derived state.
  - RR_AP:
    - First iteration: pulses rr_start and ap_start together.
    - Later iterations: pulses ap_start only; rold already holds the previous rnew.
    - rr_done and ap_done are captured in sticky flags; rold <= rr_result when rr_done is captured.
    - Leaves for PAP in the cycle after both flags are set.
  - PAP: pap_start; wait pap_done → ALPHA.
  - ALPHA: alpha_start; wait alpha_done → XR.
  - XR: xr_start; sticky-capture x_done and r_done; both set → RSNEW. Either order or the same cycle is accepted.
  - RSNEW: rsnew_start; on rsnew_done, latch rnew <= rsnew_result → CHECK.
  - CHECK (single cycle):
    - iter_count increments.
    - rnew <= TOLERANCE → DONE with converged=1.
    - Otherwise, incremented count == MAX_ITER → DONE with converged=0.
    - Otherwise → BETA.
  - BETA: beta_start; wait beta_done → PUPD.
  - PUPD: p_start; on p_done, rold <= rnew, first_iter=0 → RR_AP.
  - DONE: done=1 for one cycle → IDLE. converged, iter_count, rold and rnew hold until the next go.
- Handshake edge cases:
  - A done input asserted in any state that is not waiting for it is ignored.
  - A done arriving in the same cycle as its start pulse is accepted.
  - go while busy is ignored.
- Latency from go=1 to rr_start high: 1 cycle.

Optional Feature:
- Macro: CG_WATCHDOG_EN.
- Defined:
  - A 32-bit stage counter clears on every state entry and increments in every waiting state.
  - On reaching WDOG_LIMIT → DONE with timeout_err=1 and converged=0.
  - timeout_err holds until the next go or reset.
- Undefined: no counter; timeout_err is constant 0; a unit that never finishes hangs the FSM.

Test Plan:
- Converge in one iteration: go=1; rr_result=0x40000000; all dones returned 3 cycles after their start; rsnew_result=0x28000000 → beta_start never pulses, done=1, converged=1, iter_count=1.
- Three iterations: rsnew=0x3F800000, then 0x3E000000, then 0x20000000 → rr_start pulses only once; rold equals the previous rnew at each beta_start; converged=1, iter_count=3.
- MAX_ITER=4 with rsnew fixed at 0x3F800000 → done after 4 CHECKs, converged=0, iter_count=4.
- XR ordering: r_done 5 cycles before x_done, then both in the same cycle on the next iteration → rsnew_start fires exactly once, 1 cycle after the later done.
- Reset asserted during PAP → the next cycle shows busy=0 and all starts 0; a fresh go re-pulses rr_start.
- With CG_WATCHDOG_EN and WDOG_LIMIT=16, alpha_done withheld → timeout_err=1 and done=1 sixteen cycles after alpha_start.

Source files
------------

// File: rtl/cg_iteration_sequencer_if.sv
// Start/done handshakes and operand buses between the CG iteration sequencer
// (master) and the conjugate-gradient datapath units (slave).
interface cg_iteration_sequencer_if;
    logic        rr_start;
    logic        rr_done;
    logic [31:0] rr_result;
    logic        ap_start;
    logic        ap_done;
    logic        pap_start;
    logic        pap_done;
    logic        alpha_start;
    logic        alpha_done;
    logic        xr_start;
    logic        x_done;
    logic        r_done;
    logic        rsnew_start;
    logic        rsnew_done;
    logic [31:0] rsnew_result;
    logic        beta_start;
    logic        beta_done;
    logic        p_start;
    logic        p_done;
    logic [31:0] rold;
    logic [31:0] rnew;

    modport master (
        output rr_start, ap_start, pap_start, alpha_start, xr_start,
               rsnew_start, beta_start, p_start, rold, rnew,
        input  rr_done, rr_result, ap_done, pap_done, alpha_done, x_done,
               r_done, rsnew_done, rsnew_result, beta_done, p_done
    );

    modport slave (
        input  rr_start, ap_start, pap_start, alpha_start, xr_start,
               rsnew_start, beta_start, p_start, rold, rnew,
        output rr_done, rr_result, ap_done, pap_done, alpha_done, x_done,
               r_done, rsnew_done, rsnew_result, beta_done, p_done
    );
endinterface

// File: rtl/cg_iteration_sequencer.sv
// Central sequencing FSM for one conjugate-gradient solve: pulses each unit in
// dependency order, holds rsold/rsnew and decides convergence. CG_WATCHDOG_EN adds a per-stage watchdog.
module cg_iteration_sequencer #(
    parameter logic [31:0] TOLERANCE  = 32'h283424DC,
    parameter int          MAX_ITER   = 64,
    parameter int          ITER_W     = 16,
    parameter int          WDOG_LIMIT = 4096
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      go,
    cg_iteration_sequencer_if.master  units,
    output logic                      busy,
    output logic                      done,
    output logic                      converged,
    output logic [ITER_W-1:0]         iter_count,
    output logic                      timeout_err
);

    typedef enum logic [3:0] {
        IDLE, RR_AP, PAP, ALPHA, XR, RSNEW, CHECK, BETA, PUPD, DONE
    } state_t;

    state_t state, next_state;

    logic              rr_flag, ap_flag, x_flag, r_flag;
    logic              rr_ok, ap_ok, x_ok, r_ok;
    logic              first_iter;
    logic              entering;
    logic [31:0]       rold_q, rnew_q;
    logic              converged_q;
    logic [ITER_W-1:0] iter_q, iter_inc;
    logic              rr_start_q, ap_start_q, pap_start_q, alpha_start_q;
    logic              xr_start_q, rsnew_start_q, beta_start_q, p_start_q;

`ifdef CG_WATCHDOG_EN
    logic [31:0]       wdog_cnt;
    logic              waiting;
    logic              wdog_fire;
    logic              timeout_q;
`endif

    // A done may complete a stage in the same cycle it arrives, so the sticky
    // flags are OR-ed with the live inputs; rr is only awaited on the first pass.
    always_comb begin
        next_state = state;
        rr_ok      = ~first_iter | rr_flag | units.rr_done;
        ap_ok      = ap_flag | units.ap_done;
        x_ok       = x_flag | units.x_done;
        r_ok       = r_flag | units.r_done;
        iter_inc   = iter_q + ITER_W'(1);
        case (state)
            IDLE:    if (go) next_state = RR_AP;
            RR_AP:   if (rr_ok && ap_ok) next_state = PAP;
            PAP:     if (units.pap_done) next_state = ALPHA;
            ALPHA:   if (units.alpha_done) next_state = XR;
            XR:      if (x_ok && r_ok) next_state = RSNEW;
            RSNEW:   if (units.rsnew_done) next_state = CHECK;
            CHECK: begin
                if (rnew_q <= TOLERANCE)
                    next_state = DONE;
                else if (iter_inc == ITER_W'(MAX_ITER))
                    next_state = DONE;
                else
                    next_state = BETA;
            end
            BETA:    if (units.beta_done) next_state = PUPD;
            PUPD:    if (units.p_done) next_state = RR_AP;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
`ifdef CG_WATCHDOG_EN
        waiting   = state inside {RR_AP, PAP, ALPHA, XR, RSNEW, BETA, PUPD};
        wdog_fire = 1'b0;
        if (waiting && (next_state == state) && (wdog_cnt == 32'(WDOG_LIMIT - 1))) begin
            next_state = DONE;
            wdog_fire  = 1'b1;
        end
`endif
        entering = (next_state != state);
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Start pulses are registered off the state entry, so each fires exactly
    // once in the first cycle of its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_start_q    <= 1'b0;
            ap_start_q    <= 1'b0;
            pap_start_q   <= 1'b0;
            alpha_start_q <= 1'b0;
            xr_start_q    <= 1'b0;
            rsnew_start_q <= 1'b0;
            beta_start_q  <= 1'b0;
            p_start_q     <= 1'b0;
        end else begin
            rr_start_q    <= entering && (next_state == RR_AP) && (state == IDLE);
            ap_start_q    <= entering && (next_state == RR_AP);
            pap_start_q   <= entering && (next_state == PAP);
            alpha_start_q <= entering && (next_state == ALPHA);
            xr_start_q    <= entering && (next_state == XR);
            rsnew_start_q <= entering && (next_state == RSNEW);
            beta_start_q  <= entering && (next_state == BETA);
            p_start_q     <= entering && (next_state == PUPD);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_flag <= 1'b0;
            ap_flag <= 1'b0;
            x_flag  <= 1'b0;
            r_flag  <= 1'b0;
        end else begin
            rr_flag <= (state == RR_AP) && !entering && (rr_flag || (first_iter && units.rr_done));
            ap_flag <= (state == RR_AP) && !entering && (ap_flag || units.ap_done);
            x_flag  <= (state == XR) && !entering && (x_flag || units.x_done);
            r_flag  <= (state == XR) && !entering && (r_flag || units.r_done);
        end
    end

    // rold is loaded from r·r only on the first pass; later passes inherit rnew.
    always_ff @(posedge clk) begin
        if (reset) begin
            rold_q      <= '0;
            rnew_q      <= '0;
            converged_q <= 1'b0;
            iter_q      <= '0;
            first_iter  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        rold_q      <= '0;
                        rnew_q      <= '0;
                        converged_q <= 1'b0;
                        iter_q      <= '0;
                        first_iter  <= 1'b1;
                    end
                end
                RR_AP: begin
                    if (first_iter && units.rr_done && !rr_flag)
                        rold_q <= units.rr_result;
                end
                RSNEW: begin
                    if (units.rsnew_done)
                        rnew_q <= units.rsnew_result;
                end
                CHECK: begin
                    iter_q <= iter_inc;
                    if (rnew_q <= TOLERANCE)
                        converged_q <= 1'b1;
                end
                PUPD: begin
                    if (units.p_done) begin
                        rold_q     <= rnew_q;
                        first_iter <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CG_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (entering)
                wdog_cnt <= '0;
            else if (waiting)
                wdog_cnt <= wdog_cnt + 32'd1;
            if ((state == IDLE) && go)
                timeout_q <= 1'b0;
            else if (wdog_fire)
                timeout_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_q;
`else
    logic [31:0] wdog_limit_unused;
    assign wdog_limit_unused = 32'(WDOG_LIMIT);
    assign timeout_err       = 1'b0;
`endif

    assign units.rr_start    = rr_start_q;
    assign units.ap_start    = ap_start_q;
    assign units.pap_start   = pap_start_q;
    assign units.alpha_start = alpha_start_q;
    assign units.xr_start    = xr_start_q;
    assign units.rsnew_start = rsnew_start_q;
    assign units.beta_start  = beta_start_q;
    assign units.p_start     = p_start_q;
    assign units.rold        = rold_q;
    assign units.rnew        = rnew_q;

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign converged  = converged_q;
    assign iter_count = iter_q;

endmodule

// File: tb/tb_cg_iteration_sequencer.sv
// Self-checking bench for cg_iteration_sequencer: unit responders plus an event-order
// model of the solve derived from the rsnew sequence, tolerance and iteration limit.
module tb_cg_iteration_sequencer;

    localparam int          ITER_W = 16;
    localparam int          MAX_IT = 4;
    localparam int          WDOG   = 16;
    localparam logic [31:0] TOL    = 32'h283424DC;

    logic              clk = 1'b0;
    logic              reset;
    logic              go;
    logic              busy, done, converged, timeout_err;
    logic [ITER_W-1:0] iter_count;

    cg_iteration_sequencer_if units();

    cg_iteration_sequencer #(
        .TOLERANCE (TOL),
        .MAX_ITER  (MAX_IT),
        .ITER_W    (ITER_W),
        .WDOG_LIMIT(WDOG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .units      (units),
        .busy       (busy),
        .done       (done),
        .converged  (converged),
        .iter_count (iter_count),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Unit responders: each returns done dly cycles after its start (0 = same cycle).
    int          dly [9];
    int          x_dly_tab [8];
    int          r_dly_tab [8];
    logic [31:0] rsnew_tab [8];
    logic [31:0] rr_val;
    int          xr_k, rs_k;
    bit          hold_alpha;

    initial begin
        int         cnt [9];
        logic [8:0] st, dn;
        for (int i = 0; i < 9; i++) cnt[i] = -1;
        units.rr_done = 0; units.ap_done = 0; units.pap_done = 0; units.alpha_done = 0;
        units.x_done = 0; units.r_done = 0; units.rsnew_done = 0; units.beta_done = 0;
        units.p_done = 0; units.rr_result = '0; units.rsnew_result = '0;
        forever begin
            @(posedge clk);
            #1;
            st = {units.p_start, units.beta_start, units.rsnew_start, units.xr_start,
                  units.xr_start, units.alpha_start, units.pap_start, units.ap_start,
                  units.rr_start};
            for (int i = 0; i < 9; i++) begin
                if (st[i]) begin
                    case (i)
                        3:       cnt[i] = hold_alpha ? -1 : dly[i];
                        4:       cnt[i] = x_dly_tab[xr_k];
                        5:       cnt[i] = r_dly_tab[xr_k];
                        default: cnt[i] = dly[i];
                    endcase
                end
            end
            if (st[4]) xr_k++;
            dn = '0;
            for (int i = 0; i < 9; i++) begin
                if (cnt[i] == 0) begin
                    dn[i]  = 1'b1;
                    cnt[i] = -1;
                end else if (cnt[i] > 0) begin
                    cnt[i]--;
                end
            end
            units.rr_result = rr_val;
            if (dn[6]) begin
                units.rsnew_result = rsnew_tab[rs_k];
                rs_k++;
            end
            units.rr_done    = dn[0];
            units.ap_done    = dn[1];
            units.pap_done   = dn[2];
            units.alpha_done = dn[3];
            units.x_done     = dn[4];
            units.r_done     = dn[5];
            units.rsnew_done = dn[6];
            units.beta_done  = dn[7];
            units.p_done     = dn[8];
        end
    end

    // Model: the expected ordered list of start/done events for one solve.
    // Event bits: 0 rr,1 ap,2 pap,3 alpha,4 xr,5 rsnew,6 beta,7 p,8 done.
    logic [8:0]  exp_q [$];
    logic [31:0] exp_rold_q [$];
    logic [31:0] exp_rnew_q [$];
    bit          exp_conv, exp_timeout;
    int          exp_iters;
    logic [31:0] exp_rold_f, exp_rnew_f;
    int          rr_pulses, beta_pulses;

    task automatic buildModel(input bit stall);
        logic [31:0] prev;
        bit          stop;
        int          k;
        exp_q.delete();
        exp_rold_q.delete();
        exp_rnew_q.delete();
        exp_conv    = 0;
        exp_iters   = 0;
        exp_timeout = stall;
        exp_rold_f  = rr_val;
        exp_rnew_f  = '0;
        if (stall) begin
            exp_q.push_back(9'h003);
            exp_q.push_back(9'h004);
            exp_q.push_back(9'h008);
            exp_q.push_back(9'h100);
            return;
        end
        prev = rr_val;
        stop = 0;
        k    = 0;
        while (!stop) begin
            exp_q.push_back((k == 0) ? 9'h003 : 9'h002);
            exp_q.push_back(9'h004);
            exp_q.push_back(9'h008);
            exp_q.push_back(9'h010);
            exp_q.push_back(9'h020);
            exp_iters = k + 1;
            if (rsnew_tab[k] <= TOL) begin
                exp_conv = 1;
                stop     = 1;
            end else if (k + 1 == MAX_IT) begin
                stop = 1;
            end else begin
                exp_q.push_back(9'h040);
                exp_q.push_back(9'h080);
                exp_rold_q.push_back(prev);
                exp_rnew_q.push_back(rsnew_tab[k]);
                prev = rsnew_tab[k];
            end
            exp_rold_f = prev;
            exp_rnew_f = rsnew_tab[k];
            k++;
        end
        exp_q.push_back(9'h100);
    endtask

    // Compare process: event order, event latency, operands at beta and final status.
    initial begin
        logic [8:0] ev, dn, need, got, head;
        int         cyc, rel_cyc, lat, next_lat, stage_cyc;
        bit         busy_exp;
        cyc = 0; rel_cyc = 0; lat = 1; next_lat = 1; stage_cyc = 0;
        busy_exp = 0; need = '0; got = '0;
        forever begin
            @(negedge clk);
            cyc++;
            ev = {done, units.p_start, units.beta_start, units.rsnew_start, units.xr_start,
                  units.alpha_start, units.pap_start, units.ap_start, units.rr_start};
            dn = {units.p_done, units.beta_done, units.rsnew_done, units.r_done, units.x_done,
                  units.alpha_done, units.pap_done, units.ap_done, units.rr_done};
            checkOutput("busy", 32'(busy), 32'(busy_exp));
            if (ev != '0) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_event", 32'(ev), 32'(0));
                end else begin
                    head = exp_q.pop_front();
                    checkOutput("event_order", 32'(ev), 32'(head));
                    if (ev[8] && exp_timeout)
                        checkOutput("wdog_latency", 32'(cyc - stage_cyc), 32'(WDOG));
                    else
                        checkOutput("event_latency", 32'(cyc - rel_cyc), 32'(lat));
                    stage_cyc = cyc;
                    if (ev[0]) rr_pulses++;
                    if (ev[6]) begin
                        beta_pulses++;
                        if (exp_rold_q.size() > 0)
                            checkOutput("rold_at_beta", units.rold, exp_rold_q.pop_front());
                        if (exp_rnew_q.size() > 0)
                            checkOutput("rnew_at_beta", units.rnew, exp_rnew_q.pop_front());
                    end
                    if (ev[8]) begin
                        checkOutput("converged", 32'(converged), 32'(exp_conv));
                        checkOutput("iter_count", 32'(iter_count), 32'(exp_iters));
                        checkOutput("timeout_err", 32'(timeout_err), 32'(exp_timeout));
                        checkOutput("rold_final", units.rold, exp_rold_f);
                        if (!exp_timeout)
                            checkOutput("rnew_final", units.rnew, exp_rnew_f);
                    end
                    need     = {ev[7], ev[6], ev[5], ev[4], ev[4], ev[3], ev[2], ev[1], ev[0]};
                    got      = '0;
                    next_lat = ev[5] ? 2 : 1;
                end
            end
            if (need != '0) begin
                got = got | (dn & need);
                if (got == need) begin
                    rel_cyc = cyc;
                    lat     = next_lat;
                    need    = '0;
                end
            end
            if (reset) begin
                busy_exp = 0;
                need     = '0;
                exp_q.delete();
                exp_rold_q.delete();
                exp_rnew_q.delete();
            end else if (go && !busy_exp) begin
                busy_exp = 1;
                rel_cyc  = cyc;
                lat      = 1;
            end else if (done) begin
                busy_exp = 0;
            end
        end
    end

    task automatic applyStimulus(input bit stall, input bit wait_done);
        rr_pulses   = 0;
        beta_pulses = 0;
        xr_k        = 0;
        rs_k        = 0;
        hold_alpha  = stall;
        buildModel(stall);
        @(posedge clk);
        #1 go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        if (wait_done) begin
            for (int i = 0; i < 600; i++) begin
                @(negedge clk);
                if (done) break;
            end
            if (!done) checkOutput("done_wait", 32'(done), 32'(1));
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic setDefaults();
        for (int i = 0; i < 9; i++) dly[i] = 3;
        for (int i = 0; i < 8; i++) begin
            x_dly_tab[i] = 3;
            r_dly_tab[i] = 3;
            rsnew_tab[i] = 32'h3F800000;
        end
    endtask

    initial begin
        reset      = 1'b1;
        go         = 1'b0;
        rr_val     = 32'h40000000;
        hold_alpha = 0;
        xr_k       = 0;
        rs_k       = 0;
        setDefaults();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'(0));
        checkOutput("rst_done", 32'(done), 32'(0));
        checkOutput("rst_converged", 32'(converged), 32'(0));
        checkOutput("rst_iter", 32'(iter_count), 32'(0));
        checkOutput("rst_timeout", 32'(timeout_err), 32'(0));
        checkOutput("rst_rold", units.rold, 32'h0);
        checkOutput("rst_rnew", units.rnew, 32'h0);
        checkOutput("rst_starts", 32'({units.rr_start, units.ap_start, units.pap_start,
                    units.alpha_start, units.xr_start, units.rsnew_start, units.beta_start,
                    units.p_start}), 32'(0));

        $display("[TB] converge in one iteration");
        rsnew_tab[0] = 32'h28000000;
        applyStimulus(0, 1);
        checkOutput("t1_converged", 32'(converged), 32'(1));
        checkOutput("t1_iter", 32'(iter_count), 32'(1));
        checkOutput("t1_beta_pulses", 32'(beta_pulses), 32'(0));
        checkOutput("t1_rnew", units.rnew, 32'h28000000);

        $display("[TB] three iterations");
        setDefaults();
        rsnew_tab[0] = 32'h3F800000;
        rsnew_tab[1] = 32'h3E000000;
        rsnew_tab[2] = 32'h20000000;
        applyStimulus(0, 1);
        checkOutput("t2_converged", 32'(converged), 32'(1));
        checkOutput("t2_iter", 32'(iter_count), 32'(3));
        checkOutput("t2_rr_pulses", 32'(rr_pulses), 32'(1));
        checkOutput("t2_beta_pulses", 32'(beta_pulses), 32'(2));
        checkOutput("t2_rold", units.rold, 32'h3E000000);

        $display("[TB] iteration limit");
        setDefaults();
        for (int i = 0; i < 9; i++) dly[i] = 1;
        dly[2] = 0;
        dly[3] = 0;
        applyStimulus(0, 1);
        checkOutput("t3_converged", 32'(converged), 32'(0));
        checkOutput("t3_iter", 32'(iter_count), 32'(4));
        checkOutput("t3_beta_pulses", 32'(beta_pulses), 32'(3));

        $display("[TB] xr done ordering");
        setDefaults();
        rsnew_tab[1] = 32'h20000000;
        x_dly_tab[0] = 7;
        r_dly_tab[0] = 2;
        applyStimulus(0, 1);
        checkOutput("t4_converged", 32'(converged), 32'(1));
        checkOutput("t4_iter", 32'(iter_count), 32'(2));

        $display("[TB] reset during PAP");
        setDefaults();
        rsnew_tab[0] = 32'h28000000;
        applyStimulus(0, 0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (units.pap_start) break;
        end
        checkOutput("t5_pap_seen", 32'(units.pap_start), 32'(1));
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("t5_busy", 32'(busy), 32'(0));
        checkOutput("t5_starts", 32'({units.rr_start, units.ap_start, units.pap_start,
                    units.alpha_start, units.xr_start, units.rsnew_start, units.beta_start,
                    units.p_start}), 32'(0));
        repeat (10) @(negedge clk);
        applyStimulus(0, 1);
        checkOutput("t5_rr_pulses", 32'(rr_pulses), 32'(1));
        checkOutput("t5_converged", 32'(converged), 32'(1));
        checkOutput("t5_iter", 32'(iter_count), 32'(1));

`ifdef CG_WATCHDOG_EN
        $display("[TB] watchdog on withheld alpha_done");
        setDefaults();
        applyStimulus(1, 1);
        checkOutput("t6_timeout", 32'(timeout_err), 32'(1));
        checkOutput("t6_converged", 32'(converged), 32'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
